// File: rtl/a_rom_seq_ctrl.sv
// a_rom_seq_ctrl: column-major A-matrix ROM read sequencer streaming one element per valid/ready handshake
module a_rom_seq_ctrl #(
  parameter int ADDR_W = 4,
  parameter int ELEM_W = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          cfg_col_lo,
  input  logic [1:0]          cfg_col_hi,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [2*ELEM_W-1:0] A_input,
  output logic                elem_valid,
  input  logic                elem_ready,
  output logic [ELEM_W-1:0]   elem_data,
  output logic [2:0]          elem_row,
  output logic [1:0]          elem_col,
  output logic                busy,
  output logic                done
);
  typedef enum logic [2:0] {IDLE, ADDR, HI, LO, DONE} state_t;
  state_t state, state_nxt;
  logic [1:0] col_hi;
  logic go, hs, last;
  assign go = state == IDLE && start && !abort;
  assign hs = elem_valid && elem_ready;
  assign last = rom_addr == ADDR_W'({col_hi, 2'b11});
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = go ? (cfg_col_hi < cfg_col_lo ? DONE : ADDR) : IDLE;
      ADDR:    state_nxt = HI;
      HI:      state_nxt = hs ? LO : HI;
      LO:      state_nxt = hs ? (last ? DONE : ADDR) : LO;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && state != IDLE) state_nxt = IDLE;
  end
  // ROM address is frozen through HI/LO so A_input stays stable under backpressure
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rom_addr <= '0;
      col_hi   <= '0;
    end else begin
      state <= state_nxt;
      if (go) col_hi <= cfg_col_hi;
      if (go && cfg_col_hi >= cfg_col_lo) rom_addr <= ADDR_W'({cfg_col_lo, 2'b00});
      else if (state == LO && hs && !abort && !last) rom_addr <= rom_addr + 1'b1;
    end
  end
  assign elem_valid = state == HI || state == LO;
  assign elem_data  = state == HI ? A_input[2*ELEM_W-1:ELEM_W] : state == LO ? A_input[ELEM_W-1:0] : '0;
  assign elem_row   = elem_valid ? {rom_addr[1:0], state == LO} : '0;
  assign elem_col   = elem_valid ? rom_addr[3:2] : '0;
  assign busy       = state != IDLE;
  assign done       = state == DONE;
endmodule

// File: tb/tb_a_rom_seq_ctrl.sv
// tb_a_rom_seq_ctrl: table-driven directed checks of the A-ROM sequencer against a ROM model and expected element order
module tb_a_rom_seq_ctrl;
  logic        clk = 0;
  logic        rst, start, abort, elem_ready;
  logic [1:0]  cfg_col_lo, cfg_col_hi;
  logic [3:0]  rom_addr;
  logic [13:0] a_input;
  logic        elem_valid, busy, done;
  logic [6:0]  elem_data;
  logic [2:0]  elem_row;
  logic [1:0]  elem_col;
  logic [13:0] rom [16];
  logic [6:0]  e [32];
  int nchk = 0, nerr = 0;

  a_rom_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_col_lo(cfg_col_lo), .cfg_col_hi(cfg_col_hi),
    .rom_addr(rom_addr), .A_input(a_input),
    .elem_valid(elem_valid), .elem_ready(elem_ready),
    .elem_data(elem_data), .elem_row(elem_row), .elem_col(elem_col),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always_ff @(posedge clk) a_input <= rom[rom_addr];

  typedef struct {
    logic [1:0] lo, hi;
    int mode, n_exp, lat_exp;
  } vec_t;
  vec_t tv [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] snap();
    return {elem_valid, elem_data, elem_row, elem_col, rom_addr};
  endfunction

  // mode 0: ready=1, 1: random ready, 2: ready low 5 cycles per element, 3: ready=1 plus start pulse while busy
  task automatic run(input logic [1:0] lo, input logic [1:0] hi, input int mode,
                     output int n, output int lat, output int first_v);
    int w, c, r, idx;
    logic pend;
    logic [16:0] pv;
    n = 0; lat = -1; first_v = -1; w = 0; pend = 0; pv = '0;
    @(negedge clk);
    cfg_col_lo = lo; cfg_col_hi = hi; start = 1;
    @(posedge clk);
    for (int cyc = 0; cyc < 2000 && lat < 0; cyc++) begin
      @(negedge clk);
      start = mode == 3 && cyc == 4;
      if (start) begin cfg_col_lo = 2'd3; cfg_col_hi = 2'd0; end
      if (pend) chk("stall_hold", 32'(snap()), 32'(pv));
      if (done) begin
        lat = cyc;
        chk("busy_in_done", 32'(busy), 32'd1);
      end else if (elem_valid) begin
        if (first_v < 0) first_v = cyc;
        elem_ready = mode == 1 ? 1'($urandom_range(0, 1)) : mode == 2 ? (w >= 5) : 1'b1;
        if (elem_ready) begin
          idx = (lo * 8 + n) & 31;
          c = idx / 8; r = idx % 8;
          chk("elem", 32'(snap()), 32'({1'b1, e[idx], 3'(r), 2'(c), 4'(c * 4 + r / 2)}));
          n++; w = 0; pend = 0;
        end else begin
          w++; pend = 1; pv = snap();
        end
      end
      @(posedge clk);
    end
    start = 0;
    @(negedge clk);
    chk("idle_after", 32'({busy, done, elem_valid}), 32'd0);
  endtask

  initial begin
    int n, lat, fv;
    logic seen;
    e = '{7'h63, 7'h40, 7'h11, 7'h22, 7'h33, 7'h44, 7'h55, 7'h66,
          7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07, 7'h08,
          7'h00, 7'h00, 7'h0B, 7'h21, 7'h02, 7'h36, 7'h2B, 7'h45,
          7'h7F, 7'h10, 7'h20, 7'h30, 7'h40, 7'h50, 7'h60, 7'h6D};
    for (int k = 0; k < 16; k++) rom[k] = {e[2 * k], e[2 * k + 1]};
    tv[0] = '{2'd0, 2'd3, 0, 32, 48};
    tv[1] = '{2'd2, 2'd2, 0, 8, 12};
    tv[2] = '{2'd0, 2'd3, 1, 32, -1};
    tv[3] = '{2'd0, 2'd3, 2, 32, 208};
    tv[4] = '{2'd1, 2'd2, 0, 16, 24};
    tv[5] = '{2'd0, 2'd0, 3, 8, 12};
    tv[6] = '{2'd2, 2'd1, 0, 0, 0};
    tv[7] = '{2'd3, 2'd0, 0, 0, 0};
    rst = 0; start = 0; abort = 0; elem_ready = 0; cfg_col_lo = 0; cfg_col_hi = 0;
    repeat (3) @(negedge clk);
    chk("reset_out", 32'({snap(), busy, done}), 32'd0);
    rst = 1;
    @(negedge clk);
    chk("idle_out", 32'({snap(), busy, done}), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run(tv[i].lo, tv[i].hi, tv[i].mode, n, lat, fv);
      chk($sformatf("count_%0d", i), 32'(n), 32'(tv[i].n_exp));
      if (tv[i].lat_exp >= 0) chk($sformatf("done_lat_%0d", i), 32'(lat), 32'(tv[i].lat_exp));
      else chk($sformatf("done_seen_%0d", i), 32'(lat >= 0), 32'd1);
      chk($sformatf("first_valid_%0d", i), 32'(fv), tv[i].n_exp > 0 ? 32'd1 : 32'hFFFF_FFFF);
    end

    // abort during LO of word 5 (col 1, row 3)
    @(negedge clk);
    cfg_col_lo = 0; cfg_col_hi = 3; start = 1; elem_ready = 1;
    @(posedge clk);
    repeat (18) @(negedge clk);
    start = 0;
    chk("pre_abort", 32'({elem_valid, elem_row, elem_col, rom_addr}), 32'({1'b1, 3'd3, 2'd1, 4'd5}));
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("post_abort", 32'({elem_valid, done, busy, rom_addr}), 32'({3'b000, 4'd5}));
    seen = 0;
    repeat (3) begin @(negedge clk); seen |= done | busy; end
    chk("abort_quiet", 32'(seen), 32'd0);
    run(2'd0, 2'd3, 0, n, lat, fv);
    chk("restart_count", 32'(n), 32'd32);
    chk("restart_lat", 32'(lat), 32'd48);

    // start coincident with abort in IDLE is dropped
    start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    chk("start_abort_idle", 32'(busy), 32'd0);

    // async reset mid-HI
    cfg_col_lo = 0; cfg_col_hi = 3; start = 1;
    @(posedge clk);
    repeat (5) @(negedge clk);
    start = 0;
    chk("pre_reset_hi", 32'({elem_valid, elem_row, elem_col}), 32'({1'b1, 3'd2, 2'd0}));
    #2 rst = 0;
    #1 chk("async_reset", 32'({snap(), busy, done}), 32'd0);
    @(negedge clk);
    rst = 1;
    run(2'd0, 2'd3, 0, n, lat, fv);
    chk("post_reset_count", 32'(n), 32'd32);
    chk("post_reset_lat", 32'(lat), 32'd48);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
